// File: rtl/bram_pkg.sv
// Shared constants, clear-sequencer state type and sizing helper for the
// byte-enable simple-dual-port RAM.
package bram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    READY = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Address width for n words, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_clr_seq.sv
// Zero-fill sequencer: walks every address once, driving a full-word clear
// write each cycle while busy is high.
module bram_clr_seq
  import bram_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = clog2_min1(DEPTH),
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              busy_nxt,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_add
);

  localparam clr_state_t        RST_STATE = CLR_ON_RESET ? CLEAR : READY;
  localparam logic [ADDR_W-1:0] LAST_ADD  = ADDR_W'(DEPTH - 1);

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    clr_we    = 1'b0;
    case (state)
      READY: begin
        if (clr) state_nxt = CLEAR;
      end
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        // clr is deliberately not looked at here: a running clear never restarts.
        if (cnt == LAST_ADD) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = READY;
    endcase
  end

  assign clr_add  = cnt;
  assign busy_nxt = (state_nxt == CLEAR);

endmodule

// File: rtl/bram_sdp_be.sv
// Simple-dual-port RAM with byte-enable writes, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and a hardware zero-fill.
module bram_sdp_be
  import bram_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = clog2_min1(DEPTH),
  parameter int RD_LAT       = 1,
  parameter int RDW_MODE     = RDW_READ_FIRST,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic [ADDR_W-1:0]    wr_add,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_add,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  input  logic                 clr,
  output logic                 busy
);

  localparam int              NB      = WIDTH / 8;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              busy_nxt;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_add;

  logic              wr_in_range, rd_in_range;
  logic              wr_fire, rd_fire;
  logic [ADDR_W-1:0] wr_add_m;
  logic [NB-1:0]     wr_be_m;
  logic [WIDTH-1:0]  wr_data_m;
  logic [WIDTH-1:0]  rd_word;

  logic              vld_p0;
  logic [WIDTH-1:0]  data_p0;

  bram_clr_seq #(
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .CLR_ON_RESET (CLR_ON_RESET)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .busy_nxt (busy_nxt),
    .clr_we   (clr_we),
    .clr_add  (clr_add)
  );

  assign wr_in_range = ({1'b0, wr_add} < DEPTH_X);
  assign rd_in_range = ({1'b0, rd_add} < DEPTH_X);

  // The clear sequencer owns the write port whenever busy is high.
  always_comb begin
    wr_fire   = we & wr_in_range;
    wr_add_m  = wr_add;
    wr_be_m   = wr_be;
    wr_data_m = wr_data;
    if (busy) begin
      wr_fire   = clr_we;
      wr_add_m  = clr_add;
      wr_be_m   = '1;
      wr_data_m = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be_m[i]) mem[wr_add_m][8*i +: 8] <= wr_data_m[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_add];
      if (RDW_MODE == RDW_WRITE_FIRST && wr_fire && !busy && wr_add == rd_add) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end

  // Reads that would land while a clear is starting are dropped so that
  // rd_valid never rises and rd_data never changes during busy.
  assign rd_fire = rd_en & ~busy & ~busy_nxt;

  // Stage p0: array read register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= rd_fire;
      if (rd_fire) data_p0 <= rd_word;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic             vld_p1;
      logic [WIDTH-1:0] data_p1;

      // Stage p1: optional output register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0 & ~busy_nxt;
          if (vld_p0 & ~busy_nxt) data_p1 <= data_p0;
        end
      end

      assign rd_valid = vld_p1;
      assign rd_data  = data_p1;
    end else begin : g_lat1
      assign rd_valid = vld_p0;
      assign rd_data  = data_p0;
    end
  endgenerate

endmodule

// File: tb/tb_bram_sdp_be.sv
// Bench for bram_sdp_be: two instances (8 words/latency 1/read-first and
// 6 words/latency 2/write-first) share one stimulus stream.
module tb_bram_sdp_be;
  import bram_pkg::*;

  logic        clk = 1'b0;
  logic        rst, we, rd_en, clr;
  logic [3:0]  wr_be;
  logic [2:0]  wr_add, rd_add;
  logic [31:0] wr_data;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_sdp_be #(
    .WIDTH(32), .DEPTH(8), .RD_LAT(1), .RDW_MODE(RDW_READ_FIRST), .CLR_ON_RESET(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .we(we), .wr_be(wr_be), .wr_add(wr_add), .wr_data(wr_data),
    .rd_en(rd_en), .rd_add(rd_add), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .clr(clr), .busy(busy_a)
  );

  bram_sdp_be #(
    .WIDTH(32), .DEPTH(6), .RD_LAT(2), .RDW_MODE(RDW_WRITE_FIRST), .CLR_ON_RESET(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .we(we), .wr_be(wr_be), .wr_add(wr_add), .wr_data(wr_data),
    .rd_en(rd_en), .rd_add(rd_add), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .clr(clr), .busy(busy_b)
  );

  // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
  logic [31:0] m_mem [2][8];
  bit          m_busy [2];
  int          m_cnt [2];
  bit          m_pv [2];
  logic [31:0] m_pd [2];
  bit          m_vld [2];
  logic [31:0] m_out [2];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b1;
      m_cnt[d]  = 0;
      m_pv[d]   = 1'b0;
      m_pd[d]   = '0;
      m_vld[d]  = 1'b0;
      m_out[d]  = '0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int          dep;
      int          lat;
      bit          wf;
      bit          start;
      bit          iv;
      logic [31:0] idat;
      dep   = (d == 0) ? 8 : 6;
      lat   = (d == 0) ? 1 : 2;
      wf    = (d == 1);
      start = !m_busy[d] && clr;
      iv    = 1'b0;
      idat  = '0;
      if (!m_busy[d] && !start && rd_en) begin
        iv = 1'b1;
        if (int'(rd_add) < dep) begin
          idat = m_mem[d][rd_add];
          if (wf && we && wr_add == rd_add) idat = merge(idat, wr_data, wr_be);
        end
      end
      if (lat == 1) begin
        m_vld[d] = iv;
        if (iv) m_out[d] = idat;
      end else begin
        m_vld[d] = m_pv[d] && !start;
        if (m_vld[d]) m_out[d] = m_pd[d];
        m_pv[d] = iv;
        if (iv) m_pd[d] = idat;
      end
      if (!m_busy[d] && we && int'(wr_add) < dep)
        m_mem[d][wr_add] = merge(m_mem[d][wr_add], wr_data, wr_be);
      if (m_busy[d]) begin
        m_mem[d][m_cnt[d]] = '0;
        m_cnt[d]++;
        if (m_cnt[d] == dep) begin
          m_busy[d] = 1'b0;
          m_cnt[d]  = 0;
        end
      end else if (clr) begin
        m_busy[d] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; rd_en = 1'b0; clr = 1'b0; wr_be = 4'h0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] dat, input logic [3:0] be);
    we = 1'b1; wr_add = a; wr_data = dat; wr_be = be;
    tick();
    we = 1'b0; wr_be = 4'h0;
  endtask

  task automatic test_reset();
    int na, nb;
    rst = 1'b1; idle(); model_reset();
    tick(); tick();
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL reset_busy_a got=%0b want=1", busy_a); end
    checks++; if (busy_b !== 1'b1) begin failures++; $display("FAIL reset_busy_b got=%0b want=1", busy_b); end
    checks++; if (rd_valid_a !== 1'b0) begin failures++; $display("FAIL reset_vld_a got=%0b want=0", rd_valid_a); end
    checks++; if (rd_valid_b !== 1'b0) begin failures++; $display("FAIL reset_vld_b got=%0b want=0", rd_valid_b); end
    checks++; if (rd_data_a !== 32'h0) begin failures++; $display("FAIL reset_data_a got=%h want=0", rd_data_a); end
    checks++; if (rd_data_b !== 32'h0) begin failures++; $display("FAIL reset_data_b got=%h want=0", rd_data_b); end
    rst = 1'b0;
    na = 0; nb = 0;
    while (busy_a && na < 20) begin
      na++;
      if (busy_b) nb++;
      tick();
    end
    checks++; if (na != 8) begin failures++; $display("FAIL reset_clear_len_a got=%0d want=8", na); end
    checks++; if (nb != 6) begin failures++; $display("FAIL reset_clear_len_b got=%0d want=6", nb); end
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; rd_add = 3'(i);
      tick();
      checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h0) begin failures++; $display("FAIL reset_read_a addr=%0d got=%0b/%h want=1/0", i, rd_valid_a, rd_data_a); end
      if (i >= 1) begin
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 32'h0) begin failures++; $display("FAIL reset_read_b addr=%0d got=%0b/%h want=1/0", i - 1, rd_valid_b, rd_data_b); end
      end
    end
    rd_en = 1'b0;
    tick();
    checks++; if (rd_valid_a !== 1'b0) begin failures++; $display("FAIL reset_read_a_idle got=%0b want=0", rd_valid_a); end
    checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 32'h0) begin failures++; $display("FAIL reset_read_b_last got=%0b/%h want=1/0", rd_valid_b, rd_data_b); end
    tick();
  endtask

  task automatic test_byte_enable();
    wr(3'd3, 32'hAABBCCDD, 4'hF);
    wr(3'd3, 32'h11223344, 4'b0101);
    rd_en = 1'b1; rd_add = 3'd3;
    tick();
    rd_en = 1'b0;
    checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 32'hAA22CC44) begin failures++; $display("FAIL be_a got=%0b/%h want=1/aa22cc44", rd_valid_a, rd_data_a); end
    checks++; if (rd_valid_b !== 1'b0) begin failures++; $display("FAIL be_b_early got=%0b want=0", rd_valid_b); end
    tick();
    checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 32'hAA22CC44) begin failures++; $display("FAIL be_b got=%0b/%h want=1/aa22cc44", rd_valid_b, rd_data_b); end
    checks++; if (rd_valid_a !== 1'b0 || rd_data_a !== 32'hAA22CC44) begin failures++; $display("FAIL be_a_hold got=%0b/%h want=0/aa22cc44", rd_valid_a, rd_data_a); end
  endtask

  task automatic test_latency();
    logic [31:0] v [4];
    for (int k = 1; k <= 3; k++) begin
      v[k] = $urandom;
      wr(3'(k), v[k], 4'hF);
    end
    v[0] = '0;
    for (int k = 1; k <= 3; k++) begin
      rd_en = 1'b1; rd_add = 3'(k);
      tick();
      checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== v[k]) begin failures++; $display("FAIL lat_a addr=%0d got=%0b/%h want=1/%h", k, rd_valid_a, rd_data_a, v[k]); end
      if (k == 1) begin
        checks++; if (rd_valid_b !== 1'b0) begin failures++; $display("FAIL lat_b_first got=%0b want=0", rd_valid_b); end
      end else begin
        checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== v[k-1]) begin failures++; $display("FAIL lat_b addr=%0d got=%0b/%h want=1/%h", k - 1, rd_valid_b, rd_data_b, v[k-1]); end
      end
    end
    rd_en = 1'b0;
    tick();
    checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== v[3]) begin failures++; $display("FAIL lat_b_last got=%0b/%h want=1/%h", rd_valid_b, rd_data_b, v[3]); end
    checks++; if (rd_valid_a !== 1'b0) begin failures++; $display("FAIL lat_a_idle got=%0b want=0", rd_valid_a); end
    tick();
    checks++; if (rd_valid_b !== 1'b0 || rd_data_b !== v[3]) begin failures++; $display("FAIL lat_b_after got=%0b/%h want=0/%h", rd_valid_b, rd_data_b, v[3]); end
  endtask

  task automatic test_collision();
    wr(3'd5, 32'h0, 4'hF);
    we = 1'b1; wr_add = 3'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    rd_en = 1'b1; rd_add = 3'd5;
    tick();
    idle();
    checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h0) begin failures++; $display("FAIL coll_rf got=%0b/%h want=1/0", rd_valid_a, rd_data_a); end
    tick();
    checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 32'hDEADBEEF) begin failures++; $display("FAIL coll_wf got=%0b/%h want=1/deadbeef", rd_valid_b, rd_data_b); end
    we = 1'b1; wr_add = 3'd5; wr_data = 32'h12345678; wr_be = 4'b0011;
    rd_en = 1'b1; rd_add = 3'd5;
    tick();
    idle();
    checks++; if (rd_data_a !== 32'hDEADBEEF) begin failures++; $display("FAIL coll_rf_part got=%h want=deadbeef", rd_data_a); end
    tick();
    checks++; if (rd_data_b !== 32'hDEAD5678) begin failures++; $display("FAIL coll_wf_part got=%h want=dead5678", rd_data_b); end
  endtask

  task automatic test_reset_mid_clear();
    int na, nb;
    for (int i = 0; i < 8; i++) wr(3'(i), 32'hFFFFFFFF, 4'hF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL mid_clr_start got=%0b want=1", busy_a); end
    tick(); tick();
    rst = 1'b1; model_reset();
    #1;
    checks++; if (busy_a !== 1'b1 || rd_valid_a !== 1'b0) begin failures++; $display("FAIL mid_rst_a got=%0b/%0b want=1/0", busy_a, rd_valid_a); end
    checks++; if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin failures++; $display("FAIL mid_rst_data got=%h/%h want=0/0", rd_data_a, rd_data_b); end
    tick();
    rst = 1'b0;
    na = 0; nb = 0;
    while (busy_a && na < 20) begin
      na++;
      if (busy_b) nb++;
      clr = (na == 3);
      tick();
    end
    clr = 1'b0;
    checks++; if (na != 8) begin failures++; $display("FAIL mid_clear_len_a got=%0d want=8", na); end
    checks++; if (nb != 6) begin failures++; $display("FAIL mid_clear_len_b got=%0d want=6", nb); end
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; rd_add = 3'(i);
      tick();
      checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h0) begin failures++; $display("FAIL mid_read_a addr=%0d got=%0b/%h want=1/0", i, rd_valid_a, rd_data_a); end
      if (i >= 1) begin
        checks++; if (rd_data_b !== 32'h0) begin failures++; $display("FAIL mid_read_b addr=%0d got=%h want=0", i - 1, rd_data_b); end
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    logic [31:0] pat [6];
    for (int i = 0; i < 6; i++) begin
      pat[i] = $urandom;
      wr(3'(i), pat[i], 4'hF);
    end
    wr(3'd6, 32'h12345678, 4'hF);
    rd_en = 1'b1; rd_add = 3'd6;
    tick();
    rd_en = 1'b0;
    checks++; if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h12345678) begin failures++; $display("FAIL oor_a_inrange got=%0b/%h want=1/12345678", rd_valid_a, rd_data_a); end
    tick();
    checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== 32'h0) begin failures++; $display("FAIL oor_b got=%0b/%h want=1/0", rd_valid_b, rd_data_b); end
    for (int i = 0; i < 6; i++) begin
      rd_en = 1'b1; rd_add = 3'(i);
      tick();
      rd_en = 1'b0;
      tick();
      checks++; if (rd_valid_b !== 1'b1 || rd_data_b !== pat[i]) begin failures++; $display("FAIL oor_keep addr=%0d got=%0b/%h want=1/%h", i, rd_valid_b, rd_data_b, pat[i]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      we      = 1'($urandom_range(0, 1));
      wr_be   = 4'($urandom);
      wr_add  = 3'($urandom);
      wr_data = $urandom;
      rd_en   = 1'($urandom_range(0, 1));
      rd_add  = ($urandom_range(0, 2) == 0) ? wr_add : 3'($urandom);
      clr     = ($urandom_range(0, 39) == 0);
      tick();
      checks++; if (busy_a !== m_busy[0]) begin failures++; $display("FAIL rnd_busy_a n=%0d got=%0b want=%0b", n, busy_a, m_busy[0]); end
      checks++; if (busy_b !== m_busy[1]) begin failures++; $display("FAIL rnd_busy_b n=%0d got=%0b want=%0b", n, busy_b, m_busy[1]); end
      checks++; if (rd_valid_a !== m_vld[0]) begin failures++; $display("FAIL rnd_vld_a n=%0d got=%0b want=%0b", n, rd_valid_a, m_vld[0]); end
      checks++; if (rd_valid_b !== m_vld[1]) begin failures++; $display("FAIL rnd_vld_b n=%0d got=%0b want=%0b", n, rd_valid_b, m_vld[1]); end
      checks++; if (rd_data_a !== m_out[0]) begin failures++; $display("FAIL rnd_data_a n=%0d got=%h want=%h", n, rd_data_a, m_out[0]); end
      checks++; if (rd_data_b !== m_out[1]) begin failures++; $display("FAIL rnd_data_b n=%0d got=%h want=%h", n, rd_data_b, m_out[1]); end
    end
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; rd_en = 1'b0; clr = 1'b0;
    wr_be = '0; wr_add = '0; rd_add = '0; wr_data = '0;
    test_reset();
    test_byte_enable();
    test_latency();
    test_collision();
    test_reset_mid_clear();
    test_out_of_range();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_sdp_be.md
Name: bram_sdp_be

Overview:
- Parametrised simple-dual-port block RAM: one write port with byte enables, one read port.
- Adds configurable read latency, a selectable read-during-write mode and a valid flag.
- Adds a hardware clear sequencer that zero-fills the array after reset or on request.
- Used as the generic on-chip buffer and register-file store beneath datapath blocks; read and write ports share one clock.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 8, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH) (minimum 1), address width.
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2. Value 2 adds an output register stage.
- RDW_MODE, 0, same-address read/write collision behaviour: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data).
- CLR_ON_RESET, 1, when 1 the array is zero-filled automatically after reset release.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset of all control and output registers; does not reset array contents.
- we  in  1  write request.
- wr_be  in  WIDTH/8  byte enables; bit i gates wr_data[8i+7:8i].
- wr_add  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- rd_add  in  ADDR_W  read address.
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data carries the result of a read issued RD_LAT cycles earlier.
- clr  in  1  single-cycle pulse; starts a zero-fill.
- busy  out  1  clear in progress; user ports are ignored while high.

Behaviour:
- Reset values:
  - rd_data = 0, rd_valid = 0.
  - busy = CLR_ON_RESET.
  - FSM state = CLEAR if CLR_ON_RESET, else READY.
  - Clear counter = 0.
  - Output pipeline registers = 0.
- FSM states READY and CLEAR:
  - READY -> CLEAR when clr=1 and busy=0.
  - CLEAR writes 0 to the address equal to the counter each cycle, then increments the counter.
  - CLEAR -> READY in the cycle after address DEPTH-1 is written; busy falls in that same cycle.
  - A full clear takes exactly DEPTH cycles with busy=1.
  - clr asserted during CLEAR is ignored; no restart.
- Reset mid-clear: the async assert returns the FSM to its reset state at once. After release, the clear restarts from address 0 when CLR_ON_RESET=1; otherwise the partially cleared array is left as is.
- While busy=1:
  - we and rd_en are ignored; no array write from the user port.
  - rd_valid is 0; rd_data holds its last value.
- Write (busy=0):
  - At the rising edge where we=1, each byte i with wr_be[i]=1 is written.
  - Bytes with wr_be[i]=0 keep their value.
  - we=1 with wr_be all zero is a no-op.
- Read (busy=0):
  - rd_en=1 at edge N: rd_data is updated and rd_valid=1 after edge N+RD_LAT-1, so the result is visible in cycle N+RD_LAT.
  - rd_valid is 0 in any cycle with no matching read.
  - rd_data holds its value when no read completes.
  - Back-to-back reads are supported at one per cycle at either latency.
- Collision (we and rd_en in the same cycle, wr_add = rd_add):
  - READ_FIRST returns pre-write data.
  - WRITE_FIRST returns merged data: new bytes where wr_be=1, old bytes elsewhere.
  - Different addresses never interact.
- Out-of-range address (wr_add or rd_add >= DEPTH, possible when DEPTH is not a power of two):
  - Write is dropped.
  - Read returns 0 with rd_valid=1.
- Array contents are undefined before the first clear when CLR_ON_RESET=0.

Decomposition:
- Package bram_pkg holds:
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants.
  - FSM state typedef {READY, CLEAR}.
  - A clog2-with-minimum-1 helper function.
- Natural sub-module: bram_clr_seq, containing the FSM, the counter and the busy/clear-address/clear-write outputs.
- The top level muxes the clear write path over the user write path and owns the array and read pipeline.

Test Plan:
- Reset clear: CLR_ON_RESET=1, DEPTH=8; release rst -> busy=1 for exactly 8 cycles, then 0. Reads of addresses 0..7 return 0x00000000 with rd_valid after RD_LAT.
- Byte enables: write 0xAABBCCDD to address 3 with be=4'hF, then 0x11223344 with be=4'b0101 -> read of address 3 returns 0xAA22CC44.
- Latency: RD_LAT=2; rd_en pulses at cycles 10, 11, 12 to addresses 1, 2, 3 -> rd_valid is high in cycles 12, 13, 14 with the matching data, and low in cycle 15.
- Collision: address 5 holds 0x0; same-cycle write 0xDEADBEEF (be=F) and read of address 5 -> READ_FIRST returns 0x0; WRITE_FIRST returns 0xDEADBEEF.
- Reset mid-clear: fill memory with 0xFFFFFFFF, pulse clr, assert rst at clear cycle 3 -> busy=1 immediately (CLR_ON_RESET=1); after release the full 8-cycle clear runs and all words read 0. clr pulsed during the clear causes no extension.
- Out of range: DEPTH=6; write 0x12345678 to address 6, then read address 6 -> rd_data=0, rd_valid=1; addresses 0..5 unchanged.
